// File: rtl/new_means_calc_block_pkg.sv
// rtl/new_means_calc_block_pkg.sv - shared k-means widths, state encoding and coordinate slice helpers
package kmeans_pkg;

  localparam int COORD_W   = 13;
  localparam int ACC_W     = 22;
  localparam int CNT_W     = 10;
  localparam int NUM_CENT  = 8;
  localparam int NUM_COORD = 7;
  localparam int DATA_W    = NUM_COORD * COORD_W;
  localparam int IDX_W     = 3;

  localparam logic [ACC_W-1:0]   ACC_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [2:0] {
    CS_IDLE = 3'd0,
    CS_LOAD = 3'd1,
    CS_DIV  = 3'd2,
    CS_EMIT = 3'd3,
    CS_DONE = 3'd4
  } calc_state_t;

  function automatic logic [COORD_W-1:0] get_coord(input logic [DATA_W-1:0] data, input int i);
    return data[i*COORD_W +: COORD_W];
  endfunction

  function automatic logic [ACC_W-1:0] widen_coord(input logic [COORD_W-1:0] c);
    return {{(ACC_W-COORD_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/new_means_calc_block_if.sv
// rtl/new_means_calc_block_if.sv - point input, old-centroid mux and result stream of the mean calculator
interface new_means_calc_block_if;

  logic                          point_valid;
  logic [kmeans_pkg::DATA_W-1:0] point_data;
  logic [kmeans_pkg::IDX_W-1:0]  point_cent;
  logic                          accum_reset;
  logic                          calc_start;
  logic [kmeans_pkg::DATA_W-1:0] old_centroid_in;
  logic [kmeans_pkg::DATA_W-1:0] new_centroid_out;
  logic [kmeans_pkg::IDX_W-1:0]  cent_num;
  logic                          new_centroid_valid;
  logic                          calc_done;
  logic                          busy;
  logic                          sat_flag;

  modport slave (
    input  point_valid, point_data, point_cent, accum_reset, calc_start, old_centroid_in,
    output new_centroid_out, cent_num, new_centroid_valid, calc_done, busy, sat_flag
  );

  modport master (
    output point_valid, point_data, point_cent, accum_reset, calc_start, old_centroid_in,
    input  new_centroid_out, cent_num, new_centroid_valid, calc_done, busy, sat_flag
  );

endinterface

// File: rtl/new_means_calc_block_divider.sv
// rtl/new_means_calc_block_divider.sv - 22-bit by 10-bit restoring divider, one quotient bit per cycle
module kmeans_coord_divider
  import kmeans_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [ACC_W-1:0]   dividend_i,
  input  logic [CNT_W-1:0]   divisor_i,
  output logic               done_o,
  output logic [COORD_W-1:0] quot_o,
  output logic               clamp_o
);

  localparam logic [4:0] LAST_ITER = 5'(ACC_W - 1);

  logic             busy_q;
  logic [4:0]       iter_q;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dvs_q;
  logic [CNT_W:0]   rem_trial;
  logic             take;

  // The remainder stays below the divisor, so the trial difference is either
  // a valid remainder or wraps with its top bit set (no restore needed then).
  always_comb begin
    rem_trial = {rem_q, quo_q[ACC_W-1]} - {1'b0, dvs_q};
    take      = ~rem_trial[CNT_W];
    rem_d     = take ? rem_trial[CNT_W-1:0] : {rem_q[CNT_W-2:0], quo_q[ACC_W-1]};
    quo_d     = {quo_q[ACC_W-2:0], take};
  end

  assign done_o  = busy_q && (iter_q == LAST_ITER);
  assign clamp_o = |quo_d[ACC_W-1:COORD_W];
  assign quot_o  = clamp_o ? COORD_MAX : quo_d[COORD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      iter_q <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      iter_q <= iter_q + 5'd1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/new_means_calc_block.sv
// rtl/new_means_calc_block.sv - per-centroid sum/count accumulation and floor(sum/count) centroid update
module new_means_calc_block
  import kmeans_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  new_means_calc_block_if.slave  bus
);

  localparam logic [2:0] S_IDLE = CS_IDLE;
  localparam logic [2:0] S_LOAD = CS_LOAD;
  localparam logic [2:0] S_DIV  = CS_DIV;
  localparam logic [2:0] S_EMIT = CS_EMIT;
  localparam logic [2:0] S_DONE = CS_DONE;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cent_num_q;
  logic [DATA_W-1:0]  out_q;
  logic               valid_q, done_q;
  logic               sat_q, sat_d;

  logic [ACC_W-1:0]   sum_q [NUM_CENT][NUM_COORD];
  logic [CNT_W-1:0]   cnt_q [NUM_CENT];

  logic               accept_pt, clear_acc;
  logic [ACC_W:0]     add_raw [NUM_COORD];
  logic [ACC_W-1:0]   add_sum [NUM_COORD];
  logic               add_sat;
  logic [CNT_W-1:0]   cnt_base;
  logic               cnt_full;

  logic               div_start;
  logic               div_finish;
  logic [NUM_COORD-1:0] div_done, div_clamp;
  logic [COORD_W-1:0] div_quot [NUM_COORD];
  logic [DATA_W-1:0]  quot_packed;

  assign accept_pt  = (state_q == S_IDLE) && bus.point_valid;
  assign clear_acc  = (state_q == S_IDLE) && bus.accum_reset;
  assign div_finish = (state_q == S_DIV) && (&div_done);

  // A clear in the same cycle as a point makes the point the first entry,
  // so the adders see zero instead of the stored totals.
  always_comb begin
    add_sat  = 1'b0;
    cnt_base = clear_acc ? '0 : cnt_q[bus.point_cent];
    cnt_full = (cnt_base == CNT_MAX);
    for (int i = 0; i < NUM_COORD; i++) begin
      add_raw[i] = {1'b0, (clear_acc ? '0 : sum_q[bus.point_cent][i])}
                 + {1'b0, widen_coord(get_coord(bus.point_data, i))};
      add_sum[i] = add_raw[i][ACC_W] ? ACC_MAX : add_raw[i][ACC_W-1:0];
      add_sat    = add_sat | add_raw[i][ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CENT; k++) begin
        cnt_q[k] <= '0;
        for (int i = 0; i < NUM_COORD; i++) begin
          sum_q[k][i] <= '0;
        end
      end
    end else begin
      if (clear_acc) begin
        for (int k = 0; k < NUM_CENT; k++) begin
          cnt_q[k] <= '0;
          for (int i = 0; i < NUM_COORD; i++) begin
            sum_q[k][i] <= '0;
          end
        end
      end
      if (accept_pt) begin
        cnt_q[bus.point_cent] <= cnt_full ? cnt_base : cnt_base + CNT_W'(1);
        for (int i = 0; i < NUM_COORD; i++) begin
          sum_q[bus.point_cent][i] <= add_sum[i];
        end
      end
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (clear_acc) begin
      sat_d = 1'b0;
    end
    if (accept_pt && (add_sat || cnt_full)) begin
      sat_d = 1'b1;
    end
    if (div_finish && (|div_clamp)) begin
      sat_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.calc_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (cnt_q[idx_q] == '0) begin
          state_d = S_EMIT;
        end else begin
          state_d   = S_DIV;
          div_start = 1'b1;
        end
      end
      S_DIV: begin
        if (&div_done) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (idx_q == IDX_W'(NUM_CENT - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // cent_num leads into LOAD so the external mux presents the old centroid
  // of the cluster being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cent_num_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= (state_d == S_EMIT);
      done_q  <= (state_d == S_DONE);
      sat_q   <= sat_d;
      if (state_d == S_LOAD) begin
        cent_num_q <= idx_d;
      end
      if ((state_q == S_LOAD) && (cnt_q[idx_q] == '0)) begin
        out_q <= bus.old_centroid_in;
      end else if (div_finish) begin
        out_q <= quot_packed;
      end
    end
  end

  for (genvar g = 0; g < NUM_COORD; g++) begin : g_div
    kmeans_coord_divider u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (sum_q[idx_q][g]),
      .divisor_i  (cnt_q[idx_q]),
      .done_o     (div_done[g]),
      .quot_o     (div_quot[g]),
      .clamp_o    (div_clamp[g])
    );
    assign quot_packed[g*COORD_W +: COORD_W] = div_quot[g];
  end

  assign bus.new_centroid_out   = out_q;
  assign bus.cent_num           = cent_num_q;
  assign bus.new_centroid_valid = valid_q;
  assign bus.calc_done          = done_q;
  assign bus.busy               = (state_q != S_IDLE);
  assign bus.sat_flag           = sat_q;

endmodule
